// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise-operations stimulus path.
// Contents: sequencer state enum, operand width, the four opcodes listed in
// Gray order, and the Gray-step function that advances an opcode.
package bitwise_pkg;

  localparam int WIDTH = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Opcodes named by their position in the Gray walk 00 -> 01 -> 11 -> 10
  localparam logic [1:0] OP_G0 = 2'b00;
  localparam logic [1:0] OP_G1 = 2'b01;
  localparam logic [1:0] OP_G2 = 2'b11;
  localparam logic [1:0] OP_G3 = 2'b10;

  // Next opcode in the Gray walk; wraps from 10 back to 00
  function automatic logic [1:0] next_op(input logic [1:0] op);
    logic [1:0] nxt;
    case (op)
      OP_G0:   nxt = OP_G1;
      OP_G1:   nxt = OP_G2;
      OP_G2:   nxt = OP_G3;
      OP_G3:   nxt = OP_G0;
      default: nxt = OP_G0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_n.sv
// Fibonacci-style shift-left LFSR with a seed-load port.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (reset value SEED)
//   load        load load_val on the next edge (has priority over step)
//   load_val    new seed; an all-zero seed is replaced by 1
//   step        advance one position on the next edge
//   q           current LFSR state (registered)
module lfsr_n #(
  parameter int unsigned      WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = 7'b1100000,
  parameter logic [WIDTH-1:0] SEED  = 7'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next state: seed load wins over step; zero seed would lock the LFSR up
  always_comb begin
    q_d = q_q;
    if (load) begin
      if (load_val == ZERO) begin
        q_d = ONE;
      end else begin
        q_d = load_val;
      end
    end else if (step) begin
      q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    end else begin
      q_d = q_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bitwise_op_sequencer.sv
// Burst stimulus source for bitwise_operations.
// A start in IDLE launches a burst of len beats on a valid/ready handshake;
// a and b come from two seedable LFSRs, op walks the Gray order.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, len            burst request and length (sampled in IDLE only)
//   seed_load, seed_a/b   reseed the LFSRs (honoured in IDLE only)
//   out_valid, out_ready  beat handshake
//   a, b, op              beat payload (registered)
//   busy, done, count     status: busy in RUN/DONE, done pulse, beats accepted
module bitwise_op_sequencer
  import bitwise_pkg::*;
#(
  parameter int unsigned      WIDTH  = bitwise_pkg::WIDTH,
  parameter int unsigned      LEN_W  = 8,
  parameter logic [WIDTH-1:0] TAPS   = 7'b1100000,
  parameter logic [WIDTH-1:0] SEED_A = 7'h01,
  parameter logic [WIDTH-1:0] SEED_B = 7'h7F
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       op_q, op_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic             idle_s;
  logic             start_acc_s;
  logic             seed_ld_s;
  logic             hs_s;
  logic [LEN_W-1:0] count_inc_s;
  logic             last_hs_s;

  assign idle_s      = (state_q == ST_IDLE);
  assign start_acc_s = idle_s && start;
  assign seed_ld_s   = idle_s && seed_load;
  // out_valid is only ever high in RUN, so a handshake implies RUN
  assign hs_s        = out_valid_q && out_ready;
  assign count_inc_s = count_q + LEN_ONE;
  assign last_hs_s   = hs_s && (count_inc_s == len_q);

  // LFSR for operand a; seed load in IDLE lands before the first beat of a
  // simultaneously started burst because RUN's first beat is the next cycle
  lfsr_n #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED_A)
  ) u_lfsr_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_ld_s),
    .load_val (seed_a),
    .step     (hs_s),
    .q        (a)
  );

  lfsr_n #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED_B)
  ) u_lfsr_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_ld_s),
    .load_val (seed_b),
    .step     (hs_s),
    .q        (b)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a zero-length start goes straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == LEN_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_hs_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output decode from the next state, so the flags register in step
  // with the state they describe
  always_comb begin
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      ST_IDLE: begin
        out_valid_d = 1'b0;
      end
      ST_RUN: begin
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Burst datapath next state: op, beat count and captured length
  always_comb begin
    op_d    = op_q;
    count_d = count_q;
    len_d   = len_q;
    if (start_acc_s) begin
      op_d    = OP_G0;
      count_d = LEN_ZERO;
      len_d   = len;
    end else if (hs_s) begin
      op_d    = next_op(op_q);
      count_d = count_inc_s;
    end else begin
      op_d    = op_q;
    end
  end

  // Registered outputs and burst datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      op_q        <= OP_G0;
      count_q     <= LEN_ZERO;
      len_q       <= LEN_ZERO;
    end else begin
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      op_q        <= op_d;
      count_q     <= count_d;
      len_q       <= len_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign op        = op_q;
  assign count     = count_q;

endmodule

// File: tb/tb_bitwise_op_sequencer.sv
// Self-checking bench for bitwise_op_sequencer: a fixed cycle table for the
// basic and continuation bursts, then burst-level checks against a reference
// model that precomputes each beat from the LFSR polynomial and Gray order.
module tb_bitwise_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic       seed_load = 1'b0;
  logic [6:0] seed_a = 7'd0;
  logic [6:0] seed_b = 7'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [6:0] a, b;
  logic [1:0] op;
  logic       busy, done;
  logic [7:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  // model of the LFSR contents at the start of the next burst
  logic [6:0] ma, mb;
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  bitwise_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .seed_load (seed_load),
    .seed_a    (seed_a),
    .seed_b    (seed_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [7:0] ln;
    logic       rdy;
    logic       v;
    logic [6:0] ea;
    logic [6:0] eb;
    logic [1:0] eop;
    logic [7:0] ec;
    logic       ed;
    logic       ebz;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // x^7 + x^6 + 1: shift left, feed back bit6 xor bit5
  function automatic logic [6:0] lfsr_next(input logic [6:0] x);
    int v;
    int fb;
    v  = int'(x);
    fb = ((v >> 6) & 1) ^ ((v >> 5) & 1);
    return 7'(((v << 1) & 127) | fb);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; seed_load = 1'b0; out_ready = 1'b0;
    len = 8'd0; seed_a = 7'd0; seed_b = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_a", a, 7'h01);
    check("rst_b", b, 7'h7F);
    check("rst_op", op, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    rst_n = 1'b1;
    ma = 7'h01;
    mb = 7'h7F;
  endtask

  // Run one burst of n beats and check every cycle against precomputed beats.
  task automatic do_burst(input int n, input bit rnd_ready, input int stall_at,
                          input int stall_len, input bit with_seed,
                          input logic [6:0] sa, input logic [6:0] sb, input bit noise);
    logic [6:0] ea, eb;
    int k, stalled, cyc;
    bit rdy;
    if (with_seed) begin
      ma = (sa == 7'd0) ? 7'd1 : sa;
      mb = (sb == 7'd0) ? 7'd1 : sb;
    end
    ea = ma; eb = mb; k = 0; stalled = 0; cyc = 0;
    start = 1'b1; len = 8'(n); seed_load = with_seed; seed_a = sa; seed_b = sb;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0; seed_load = 1'b0;
    if (n == 0) begin
      check("empty_done", done, 1);
      check("empty_valid", out_valid, 0);
      check("empty_busy", busy, 1);
      check("empty_count", count, 0);
      @(posedge clk); #1;
      check("empty_done_clear", done, 0);
      check("empty_valid2", out_valid, 0);
      check("empty_busy_clear", busy, 0);
      return;
    end
    while (k < n && cyc < 20 * n + 50) begin
      check("beat_valid", out_valid, 1);
      check("beat_a", a, ea);
      check("beat_b", b, eb);
      check("beat_op", op, gray[k % 4]);
      check("beat_count", count, k);
      check("beat_done", done, 0);
      check("beat_busy", busy, 1);
      if (stall_at == k && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else begin
        rdy = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      out_ready = rdy;
      if (noise) begin
        start     = 1'($urandom_range(0, 1));
        len       = 8'($urandom);
        seed_load = 1'($urandom_range(0, 1));
        seed_a    = 7'($urandom);
        seed_b    = 7'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        k++;
        ea = lfsr_next(ea);
        eb = lfsr_next(eb);
      end
    end
    start = 1'b0; seed_load = 1'b0;
    if (k < n) check("burst_timeout_beats", k, n);
    check("end_done", done, 1);
    check("end_valid", out_valid, 0);
    check("end_busy", busy, 1);
    check("end_count", count, n);
    @(posedge clk); #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
    check("idle_count", count, n);
    ma = ea;
    mb = eb;
  endtask

  initial begin
    //          st    len    rdy   v     a      b      op     count  done  busy
    tbl[0]  = '{1'b1, 8'd4, 1'b1, 1'b1, 7'h01, 7'h7F, 2'b00, 8'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 8'd0, 1'b1, 1'b1, 7'h02, 7'h7E, 2'b01, 8'd1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 8'd0, 1'b1, 1'b1, 7'h04, 7'h7C, 2'b11, 8'd2, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 8'd0, 1'b1, 1'b1, 7'h08, 7'h78, 2'b10, 8'd3, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 8'd9, 1'b1, 1'b0, 7'h10, 7'h70, 2'b00, 8'd4, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 8'd9, 1'b1, 1'b0, 7'h10, 7'h70, 2'b00, 8'd4, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'd4, 1'b1, 1'b1, 7'h10, 7'h70, 2'b00, 8'd0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 8'd0, 1'b1, 1'b1, 7'h20, 7'h60, 2'b01, 8'd1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 8'd0, 1'b1, 1'b1, 7'h41, 7'h40, 2'b11, 8'd2, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'd0, 1'b1, 1'b1, 7'h03, 7'h01, 2'b10, 8'd3, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 8'd0, 1'b1, 1'b0, 7'h06, 7'h02, 2'b00, 8'd4, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 8'd0, 1'b1, 1'b0, 7'h06, 7'h02, 2'b00, 8'd4, 1'b0, 1'b0};

    do_reset();

    // basic burst, then continuation (start pulses in RUN/DONE are ignored)
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st; len = tbl[i].ln; out_ready = tbl[i].rdy;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].v);
      check($sformatf("tbl%0d_a", i), a, tbl[i].ea);
      check($sformatf("tbl%0d_b", i), b, tbl[i].eb);
      check($sformatf("tbl%0d_op", i), op, tbl[i].eop);
      check($sformatf("tbl%0d_count", i), count, tbl[i].ec);
      check($sformatf("tbl%0d_done", i), done, tbl[i].ed);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].ebz);
    end
    start = 1'b0;

    // stall for 3 cycles on beat 2 of a fresh len=4 burst
    do_reset();
    do_burst(4, 1'b0, 1, 3, 1'b0, 7'd0, 7'd0, 1'b0);

    // empty burst, then len=6 for the op wrap
    do_burst(0, 1'b0, -1, 0, 1'b0, 7'd0, 7'd0, 1'b0);
    do_burst(6, 1'b0, -1, 0, 1'b0, 7'd0, 7'd0, 1'b0);

    // seed load in IDLE with a zero seed for a
    seed_load = 1'b1; seed_a = 7'h00; seed_b = 7'h55;
    @(posedge clk); #1;
    seed_load = 1'b0;
    check("seed_a_zero_fix", a, 7'h01);
    check("seed_b_loaded", b, 7'h55);
    check("seed_no_busy", busy, 0);
    ma = 7'h01; mb = 7'h55;
    do_burst(2, 1'b0, -1, 0, 1'b0, 7'd0, 7'd0, 1'b0);

    // async reset during beat 3 of a len=8 burst
    start = 1'b1; len = 8'd8; out_ready = 1'b1;
    @(posedge clk); #1;
    repeat (2) begin
      start = 1'b1; len = 8'd3;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("s6_beat3_valid", out_valid, 1);
    check("s6_beat3_count", count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("s6_async_valid", out_valid, 0);
    check("s6_async_a", a, 7'h01);
    check("s6_async_b", b, 7'h7F);
    check("s6_async_op", op, 0);
    check("s6_async_busy", busy, 0);
    check("s6_async_done", done, 0);
    check("s6_async_count", count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("s6_no_done", done, 0);
      check("s6_no_valid", out_valid, 0);
      check("s6_no_busy", busy, 0);
    end
    ma = 7'h01; mb = 7'h7F;

    // randomized bursts with back-pressure, reseeds and ignored requests
    for (int i = 0; i < 15; i++) begin
      logic [6:0] sa, sb;
      sa = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom);
      sb = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom);
      do_burst(int'($urandom_range(0, 12)), 1'b1, -1, 0,
               ($urandom_range(0, 2) == 0), sa, sb, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
